sha256_block_seq: RTL and testbench

SHA256_BLOCK_SEQ -- requirements
Module: sha256_block_seq

---
 rtl/sha256_block_seq.sv | 135 +++++++++++++
 tb/tb_sha256_block_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_seq.sv
`default_nettype none
// ============================================================================
// sha256_block_seq : turns a byte stream into padded SHA-256 512-bit blocks
// Revision: 1.0
// ============================================================================
module sha256_block_seq #(
  parameter int LEN_W = 61
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         blk_valid,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_ready,
  output logic         msg_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_LEN  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           r_after_emit;
  logic [7:0]       r_buf [0:63];
  logic [5:0]       r_ptr;
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_first_pend;
  logic             r_final_pend;
  logic             r_msg_done;
  logic             r_busy;

  logic             w_accept;
  logic             w_emit;
  logic [LEN_W+2:0] w_bits;
  logic [63:0]      w_bitlen;
  logic [511:0]     w_packed;

  assign in_ready  = (r_state == S_FILL) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = (r_state == S_EMIT) && !rst;
  assign w_bits    = {r_byte_cnt, 3'b000};
  assign w_bitlen  = 64'(w_bits);

  assign blk_valid = w_emit;
  assign blk_first = w_emit && r_first_pend;
  assign blk_last  = w_emit && r_final_pend;
  assign blk_data  = rst ? 512'd0 : w_packed;
  assign msg_done  = r_msg_done;
  assign busy      = r_busy;

  for (genvar gi = 0; gi < 64; gi++) begin : g_pack
    assign w_packed[511-8*gi -: 8] = r_buf[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FILL;
      r_after_emit <= S_FILL;
      r_ptr        <= 6'd0;
      r_byte_cnt   <= '0;
      r_first_pend <= 1'b1;
      r_final_pend <= 1'b0;
      r_msg_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_buf        <= '{default: 8'h00};
    end else begin
      r_msg_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_buf[r_ptr] <= in_data;
            r_byte_cnt   <= r_byte_cnt + LEN_W'(1);
            r_busy       <= 1'b1;
            if (r_ptr == 6'd63) begin
              // Full block goes out first; a final byte here still needs a padding block.
              r_final_pend <= 1'b0;
              r_after_emit <= in_last ? S_PAD : S_FILL;
              r_state      <= S_EMIT;
            end else begin
              r_ptr <= r_ptr + 6'd1;
              if (in_last) begin
                r_state <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          r_buf[r_ptr] <= 8'h80;
          if (r_ptr <= 6'd55) begin
            r_state <= S_LEN;
          end else begin
            r_final_pend <= 1'b0;
            r_after_emit <= S_LEN;
            r_state      <= S_EMIT;
          end
        end
        S_LEN: begin
          for (int i = 0; i < 8; i++) begin
            r_buf[6'(56 + i)] <= w_bitlen[63-8*i -: 8];
          end
          r_final_pend <= 1'b1;
          r_state      <= S_EMIT;
        end
        S_EMIT: begin
          if (blk_ready) begin
            r_buf        <= '{default: 8'h00};
            r_ptr        <= 6'd0;
            r_first_pend <= 1'b0;
            if (r_final_pend) begin
              r_byte_cnt   <= '0;
              r_first_pend <= 1'b1;
              r_final_pend <= 1'b0;
              r_msg_done   <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_FILL;
            end else begin
              r_state <= r_after_emit;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_seq.sv
`default_nettype none
// ============================================================================
// tb_sha256_block_seq : randomized scoreboard bench for sha256_block_seq
// Revision: 1.0
// ============================================================================
module tb_sha256_block_seq;

  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready = 1'b1;
  logic         msg_done;
  logic         busy;

  int           n_tests = 0;
  int           n_fail = 0;
  int           ready_mode = 0;
  int           n_pushed = 0;
  int           n_popped = 0;
  blk_t         exp_q[$];
  byte unsigned g_msg[$];

  sha256_block_seq #(.LEN_W(61)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready),
    .msg_done  (msg_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Standard SHA-256 padding of the whole message, then cut into 64-byte blocks.
  task automatic push_expected(input int n);
    byte unsigned    p[$];
    longint unsigned bits;
    int              nblk;
    blk_t            e;
    p = g_msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = longint'(n) * 8;
    for (int b = 7; b >= 0; b--) p.push_back(bits[8*b +: 8]);
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*k + j];
      e.first = (k == 0);
      e.last  = (k == nblk - 1);
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       blk_ready = 1'b1;
      1:       blk_ready = ($urandom_range(0, 2) != 0);
      default: blk_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every block handshake.
  logic         prev_stall = 1'b0;
  logic [513:0] held;
  logic         exp_done = 1'b0;
  blk_t         got;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (in_ready && blk_valid) chk("ready_and_valid_overlap", 1, 0);
      if (prev_stall && blk_valid) chk("stall_stable", {blk_data, blk_first, blk_last}, held);
      if (msg_done || exp_done) begin
        chk("msg_done", msg_done, exp_done);
        chk("busy_at_done", busy, 0);
      end
      exp_done = 1'b0;
      if (blk_valid && blk_ready) begin
        n_popped++;
        if (exp_q.size() == 0) begin
          chk("unexpected_block", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("blk_data", blk_data, got.data);
          chk("blk_first", blk_first, got.first);
          chk("blk_last", blk_last, got.last);
          chk("busy_in_emit", busy, 1);
          exp_done = got.last;
        end
      end
      prev_stall = blk_valid && !blk_ready;
      held = {blk_data, blk_first, blk_last};
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_blk_valid", blk_valid, 0);
    chk("post_reset_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // Sends g_msg[0..n-1]; abort_at >= 0 pulses reset before that byte instead.
  task automatic send_msg(input int n, input bit lat, input int abort_at);
    int  waits;
    bit  acc;
    int  k;
    if (abort_at < 0) push_expected(n);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        repeat (4) @(posedge clk);
        #1;
        chk("abort_blk_valid", blk_valid, (abort_at % 64) == 0);
        do_reset();
        return;
      end
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = g_msg[i];
      in_last  = (i == n - 1);
      waits = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        waits++;
        if (!acc && waits > 2000) begin
          chk("byte_accept_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (lat) begin
      k = 0;
      do begin
        k++;
        @(negedge clk);
      end while (!blk_valid && k < 10);
      chk("abc_latency", k, 3);
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_seq(input int n);
    g_msg.delete();
    for (int i = 0; i < n; i++) g_msg.push_back(8'(i));
  endtask

  task automatic fill_abc();
    g_msg.delete();
    g_msg.push_back(8'h61);
    g_msg.push_back(8'h62);
    g_msg.push_back(8'h63);
  endtask

  task automatic wait_drain(input int lim);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || blk_valid) && c < lim) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_in_time", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int lens[6];
    int n;
    lens = '{55, 56, 63, 64, 119, 120};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_data", blk_data, 0);
    chk("rst_blk_first", blk_first, 0);
    chk("rst_blk_last", blk_last, 0);
    chk("rst_msg_done", msg_done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    ready_mode = 0;
    fill_abc();
    send_msg(3, 1'b1, -1);
    wait_drain(200);
    foreach (lens[j]) begin
      fill_seq(lens[j]);
      send_msg(lens[j], 1'b0, -1);
    end
    wait_drain(500);

    ready_mode = 2;
    fill_abc();
    send_msg(3, 1'b0, -1);
    n = 0;
    while (!blk_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_valid_held", blk_valid, 1);
    chk("stall_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    ready_mode = 0;
    wait_drain(100);

    ready_mode = 0;
    fill_seq(40);
    send_msg(40, 1'b0, 20);
    ready_mode = 2;
    fill_seq(70);
    send_msg(70, 1'b0, 64);
    ready_mode = 0;
    fill_abc();
    send_msg(3, 1'b1, -1);
    wait_drain(200);

    ready_mode = 1;
    for (int m = 0; m < 25; m++) begin
      n = ($urandom_range(0, 2) == 0) ? lens[$urandom_range(0, 5)] : $urandom_range(1, 140);
      g_msg.delete();
      for (int i = 0; i < n; i++) g_msg.push_back(8'($urandom_range(0, 255)));
      send_msg(n, 1'b0, -1);
    end
    wait_drain(5000);
    chk("block_count", n_popped, n_pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    chk("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
